// File: rtl/objective_if.sv
`default_nettype none
// ============================================================================
//  objective_if : target/result/error/loss stream bundle for objective
//  Rev 1.0
// ============================================================================
interface objective_if #(
   parameter int W = 16,
   parameter int L = 24
);
   logic         target_valid;
   logic         target_ready;
   logic [W-1:0] target_data;
   logic         result_valid;
   logic         result_ready;
   logic [W-1:0] result_data;
   logic         error_valid;
   logic         error_ready;
   logic [W-1:0] error_data;
   logic         loss_valid;
   logic         loss_ready;
   logic [L-1:0] loss_data;

   modport slave (
      input  target_valid, target_data,
      output target_ready,
      input  result_valid, result_data,
      output result_ready,
      output error_valid, error_data,
      input  error_ready,
      output loss_valid, loss_data,
      input  loss_ready
   );

   modport master (
      output target_valid, target_data,
      input  target_ready,
      output result_valid, result_data,
      input  result_ready,
      input  error_valid, error_data,
      output error_ready,
      input  loss_valid, loss_data,
      output loss_ready
   );
endinterface
`default_nettype wire

// File: rtl/objective.sv
`default_nettype none
// ============================================================================
//  objective : signed error (target - result) generator with batch L1 loss
//  Rev 1.0
// ============================================================================
module objective #(
   parameter int W = 16,
   parameter int N = 4,
   parameter int L = 24
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        train,
   objective_if.slave  bus
);
   localparam int            CW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_ERROR   = 2'd1,
      S_LOSS    = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [W-1:0]   r_tgt;
   logic [W-1:0]   r_res;
   logic           r_have_t;
   logic           r_have_r;
   logic [CW-1:0]  r_cnt;
   logic [L-1:0]   r_acc;
   logic [W-1:0]   r_err;
   logic [L-1:0]   r_loss;

   logic           w_tgt_fire;
   logic           w_res_fire;
   logic [W-1:0]   w_tgt;
   logic [W-1:0]   w_res;
   logic [W:0]     w_diff;
   logic [W-1:0]   w_e;
   logic [W-1:0]   w_abs;
   logic [L:0]     w_sum;
   logic [L-1:0]   w_acc_sat;
   logic           w_capture;
   logic           w_advance;

   // Readiness depends only on registered state, so fires never loop through bus.*_ready.
   assign w_tgt_fire = (r_state == S_COLLECT) && !r_have_t && bus.target_valid;
   assign w_res_fire = (r_state == S_COLLECT) && !r_have_r && bus.result_valid;

   assign w_tgt  = r_have_t ? r_tgt : bus.target_data;
   assign w_res  = r_have_r ? r_res : bus.result_data;
   assign w_diff = {w_tgt[W-1], w_tgt} - {w_res[W-1], w_res};

   always_comb begin
      w_e = w_diff[W-1:0];
      if (w_diff[W] != w_diff[W-1]) begin
         w_e = w_diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

   // |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits.
   assign w_abs     = w_e[W-1] ? ((~w_e) + W'(1)) : w_e;
   assign w_sum     = {1'b0, r_acc} + (L+1)'(w_abs);
   assign w_acc_sat = w_sum[L] ? {L{1'b1}} : w_sum[L-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_COLLECT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next           = r_state;
      w_capture        = 1'b0;
      w_advance        = 1'b0;
      bus.target_ready = 1'b0;
      bus.result_ready = 1'b0;
      bus.error_valid  = 1'b0;
      bus.loss_valid   = 1'b0;
      case (r_state)
         S_COLLECT: begin
            bus.target_ready = !r_have_t;
            bus.result_ready = !r_have_r;
            w_capture = (r_have_t || bus.target_valid) && (r_have_r || bus.result_valid);
            if (w_capture) begin
               if (train) begin
                  w_next = S_ERROR;
               end else begin
                  w_advance = 1'b1;
                  w_next    = (r_cnt == C_LAST) ? S_LOSS : S_COLLECT;
               end
            end
         end
         S_ERROR: begin
            bus.error_valid = 1'b1;
            if (bus.error_ready) begin
               w_advance = 1'b1;
               w_next    = (r_cnt == C_LAST) ? S_LOSS : S_COLLECT;
            end
         end
         S_LOSS: begin
            bus.loss_valid = 1'b1;
            if (bus.loss_ready) begin
               w_next = S_COLLECT;
            end
         end
         default: w_next = S_COLLECT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_tgt    <= '0;
         r_res    <= '0;
         r_have_t <= 1'b0;
         r_have_r <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_err    <= '0;
         r_loss   <= '0;
      end else begin
         if (w_tgt_fire) begin
            r_tgt    <= bus.target_data;
            r_have_t <= 1'b1;
         end
         if (w_res_fire) begin
            r_res    <= bus.result_data;
            r_have_r <= 1'b1;
         end
         if (w_capture) begin
            r_have_t <= 1'b0;
            r_have_r <= 1'b0;
            r_acc    <= w_acc_sat;
            if (train) begin
               r_err <= w_e;
            end
         end
         // In inference the current |e| is only on w_acc_sat; from ERROR it is already in r_acc.
         if (w_advance) begin
            if (r_cnt == C_LAST) begin
               r_cnt  <= '0;
               r_loss <= (r_state == S_COLLECT) ? w_acc_sat : r_acc;
               r_acc  <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign bus.error_data = r_err;
   assign bus.loss_data  = r_loss;
endmodule
`default_nettype wire

// File: tb/tb_objective.sv
`default_nettype none
// ============================================================================
//  tb_objective : directed and randomized self-checking bench for objective
//  Rev 1.0
// ============================================================================
module tb_objective;
   localparam int W = 16;
   localparam int N = 4;
   localparam int L = 24;
   localparam longint C_LMAX = (64'd1 << L) - 1;

   logic clock;
   logic reset;
   logic train;
   int   n_tests;
   int   n_fail;

   objective_if #(.W(W), .L(L)) bus ();

   objective #(.W(W), .N(N), .L(L)) dut (
      .clock (clock),
      .reset (reset),
      .train (train),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int ref_err(input logic [W-1:0] t, input logic [W-1:0] r);
      int d;
      d = int'($signed(t)) - int'($signed(r));
      if (d > (1 << (W-1)) - 1) d = (1 << (W-1)) - 1;
      if (d < -(1 << (W-1)))    d = -(1 << (W-1));
      return d;
   endfunction

   function automatic logic [W-1:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return 16'h7fff;
         1:       return 16'h8000;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic do_reset(input int n);
      reset = 1'b1;
      bus.target_valid = 1'b0; bus.result_valid = 1'b0;
      bus.target_data  = '0;   bus.result_data  = '0;
      bus.error_ready  = 1'b0; bus.loss_ready   = 1'b0;
      repeat (n) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic push_both(input logic [W-1:0] t, input logic [W-1:0] r, output bit ok);
      bit ta, ra;
      bus.target_valid = 1'b1; bus.target_data = t;
      bus.result_valid = 1'b1; bus.result_data = r;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         ta = bus.target_valid && bus.target_ready;
         ra = bus.result_valid && bus.result_ready;
         @(posedge clock); #1;
         if (ta) bus.target_valid = 1'b0;
         if (ra) bus.result_valid = 1'b0;
         if (!bus.target_valid && !bus.result_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_loss(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.loss_valid) begin ok = 1'b1; break; end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset();
      do_reset(2);
      n_tests++; if ({bus.target_ready, bus.result_ready} !== 2'b11) begin n_fail++;
         $display("FAIL reset_ready: got %b expected 11", {bus.target_ready, bus.result_ready}); end
      n_tests++; if ({bus.error_valid, bus.loss_valid} !== 2'b00) begin n_fail++;
         $display("FAIL reset_valid: got %b expected 00", {bus.error_valid, bus.loss_valid}); end
      n_tests++; if (bus.error_data !== '0 || bus.loss_data !== '0) begin n_fail++;
         $display("FAIL reset_data: got err %h loss %h expected 0", bus.error_data, bus.loss_data); end
   endtask

   task automatic test_basic();
      bit ok;
      do_reset(2);
      train = 1'b1;
      push_both(16'h007f, 16'hfff4, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_accept: got timeout expected accept"); end
      for (int k = 0; k < 4; k++) begin
         n_tests++; if (bus.error_valid !== 1'b1 || bus.error_data !== 16'h008b) begin n_fail++;
            $display("FAIL basic_err[%0d]: got v=%b d=%h expected v=1 d=008b", k, bus.error_valid, bus.error_data); end
         n_tests++; if ({bus.target_ready, bus.result_ready} !== 2'b00) begin n_fail++;
            $display("FAIL basic_ready[%0d]: got %b expected 00", k, {bus.target_ready, bus.result_ready}); end
         if (k < 3) begin @(posedge clock); #1; end
      end
      bus.error_ready = 1'b1;
      @(posedge clock); #1;
      bus.error_ready = 1'b0;
      n_tests++; if (bus.error_valid !== 1'b0 || bus.error_data !== 16'h008b) begin n_fail++;
         $display("FAIL basic_after: got v=%b d=%h expected v=0 d=008b", bus.error_valid, bus.error_data); end
   endtask

   task automatic test_saturation();
      bit ok;
      do_reset(1);
      train = 1'b1;
      push_both(16'h7fff, 16'h8000, ok);
      n_tests++; if (!ok || bus.error_data !== 16'h7fff) begin n_fail++;
         $display("FAIL sat_pos: got ok=%b d=%h expected 7fff", ok, bus.error_data); end
      bus.error_ready = 1'b1;
      push_both(16'h8000, 16'h7fff, ok);
      n_tests++; if (!ok || bus.error_data !== 16'h8000) begin n_fail++;
         $display("FAIL sat_neg: got ok=%b d=%h expected 8000", ok, bus.error_data); end
      push_both(16'h1234, 16'h1234, ok);
      push_both(16'h0000, 16'h0000, ok);
      wait_loss(ok);
      n_tests++; if (!ok || bus.loss_data !== 24'h00ffff) begin n_fail++;
         $display("FAIL sat_loss: got ok=%b d=%h expected 00ffff", ok, bus.loss_data); end
      bus.loss_ready = 1'b1;
      @(posedge clock); #1;
      bus.loss_ready = 1'b0; bus.error_ready = 1'b0;
   endtask

   task automatic test_order();
      do_reset(1);
      train = 1'b1;
      bus.result_valid = 1'b1; bus.result_data = 16'h0010;
      @(posedge clock); #1;
      bus.result_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_tests++; if ({bus.target_ready, bus.result_ready} !== 2'b10) begin n_fail++;
            $display("FAIL order_ready[%0d]: got %b expected 10", k, {bus.target_ready, bus.result_ready}); end
         if (k == 0) begin @(posedge clock); #1; end
      end
      bus.target_valid = 1'b1; bus.target_data = 16'h0020;
      @(posedge clock); #1;
      bus.target_valid = 1'b0;
      n_tests++; if (bus.error_valid !== 1'b1 || bus.error_data !== 16'h0010) begin n_fail++;
         $display("FAIL order_err: got v=%b d=%h expected v=1 d=0010", bus.error_valid, bus.error_data); end
   endtask

   task automatic test_batch();
      logic [W-1:0] tv [4] = '{16'h007f, 16'h0000, 16'h0012, 16'h0003};
      logic [W-1:0] rv [4] = '{16'hfff4, 16'h0005, 16'h0012, 16'h0001};
      bit ok;
      int sum;
      do_reset(1);
      train = 1'b1; bus.error_ready = 1'b1;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         push_both(tv[i], rv[i], ok);
         sum += (ref_err(tv[i], rv[i]) < 0) ? -ref_err(tv[i], rv[i]) : ref_err(tv[i], rv[i]);
      end
      wait_loss(ok);
      n_tests++; if (!ok || bus.loss_data !== L'(sum) || bus.loss_data !== 24'h000092) begin n_fail++;
         $display("FAIL batch_loss: got ok=%b d=%h expected 000092", ok, bus.loss_data); end
      bus.target_valid = 1'b1; bus.result_valid = 1'b1;
      bus.target_data = 16'h0009; bus.result_data = 16'h0009;
      for (int k = 0; k < 5; k++) begin
         n_tests++; if ({bus.target_ready, bus.result_ready, bus.loss_valid} !== 3'b001) begin n_fail++;
            $display("FAIL batch_hold[%0d]: got %b expected 001", k, {bus.target_ready, bus.result_ready, bus.loss_valid}); end
         @(posedge clock); #1;
      end
      bus.target_valid = 1'b0; bus.result_valid = 1'b0;
      bus.loss_ready = 1'b1;
      @(posedge clock); #1;
      bus.loss_ready = 1'b0;
      n_tests++; if (bus.loss_valid !== 1'b0) begin n_fail++;
         $display("FAIL batch_release: got %b expected 0", bus.loss_valid); end
      sum = 0;
      for (int i = 1; i <= 4; i++) begin
         push_both(W'(100 + i), 16'd100, ok);
         sum += i;
      end
      wait_loss(ok);
      n_tests++; if (!ok || bus.loss_data !== L'(sum)) begin n_fail++;
         $display("FAIL batch_second: got ok=%b d=%h expected %h", ok, bus.loss_data, L'(sum)); end
      bus.loss_ready = 1'b1;
      @(posedge clock); #1;
      bus.loss_ready = 1'b0; bus.error_ready = 1'b0;
   endtask

   task automatic test_inference();
      do_reset(1);
      train = 1'b0;
      bus.target_valid = 1'b1; bus.result_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.target_data = W'(50 + ((i % 2 == 0) ? 1 : -1));
         bus.result_data = 16'd50;
         n_tests++; if ({bus.target_ready, bus.result_ready} !== 2'b11) begin n_fail++;
            $display("FAIL infer_ready[%0d]: got %b expected 11", i, {bus.target_ready, bus.result_ready}); end
         @(posedge clock); #1;
         n_tests++; if (bus.error_valid !== 1'b0) begin n_fail++;
            $display("FAIL infer_errv[%0d]: got %b expected 0", i, bus.error_valid); end
      end
      bus.target_valid = 1'b0; bus.result_valid = 1'b0;
      n_tests++; if (bus.loss_valid !== 1'b1 || bus.loss_data !== 24'd4) begin n_fail++;
         $display("FAIL infer_loss: got v=%b d=%h expected v=1 d=000004", bus.loss_valid, bus.loss_data); end
      bus.loss_ready = 1'b1;
      @(posedge clock); #1;
      bus.loss_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset(1);
      train = 1'b1;
      push_both(16'd10, 16'd5, ok);
      bus.error_ready = 1'b1;
      @(posedge clock); #1;
      bus.error_ready = 1'b0;
      push_both(16'd20, 16'd10, ok);
      n_tests++; if (bus.error_valid !== 1'b1) begin n_fail++;
         $display("FAIL mid_pre: got %b expected 1", bus.error_valid); end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      n_tests++; if ({bus.error_valid, bus.loss_valid, bus.target_ready, bus.result_ready} !== 4'b0011) begin n_fail++;
         $display("FAIL mid_reset: got %b expected 0011",
                  {bus.error_valid, bus.loss_valid, bus.target_ready, bus.result_ready}); end
      bus.error_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_both(16'd7, 16'd4, ok);
      wait_loss(ok);
      n_tests++; if (!ok || bus.loss_data !== 24'd12) begin n_fail++;
         $display("FAIL mid_loss: got ok=%b d=%h expected 00000c", ok, bus.loss_data); end
      bus.loss_ready = 1'b1;
      @(posedge clock); #1;
      bus.loss_ready = 1'b0; bus.error_ready = 1'b0;
   endtask

   task automatic test_random(input int cycles);
      logic [W-1:0] tq [$];
      logic [W-1:0] rq [$];
      logic [W-1:0] exp_err [$];
      logic [L-1:0] exp_loss [$];
      logic [W-1:0] t, r, ee;
      logic [L-1:0] el;
      longint acc;
      int cnt, e;
      bit ta, ra, ea, la;
      do_reset(1);
      acc = 0; cnt = 0;
      for (int c = 0; c < cycles + 60; c++) begin
         if (c < cycles) begin
            if (!bus.target_valid && $urandom_range(0, 2) != 0) begin
               bus.target_valid = 1'b1; bus.target_data = rand_word(); end
            if (!bus.result_valid && $urandom_range(0, 2) != 0) begin
               bus.result_valid = 1'b1; bus.result_data = rand_word(); end
            train = 1'($urandom_range(0, 1));
            bus.error_ready = ($urandom_range(0, 3) != 0);
            bus.loss_ready  = ($urandom_range(0, 3) != 0);
         end else begin
            bus.error_ready = 1'b1; bus.loss_ready = 1'b1;
         end
         ta = bus.target_valid && bus.target_ready;
         ra = bus.result_valid && bus.result_ready;
         ea = bus.error_valid && bus.error_ready;
         la = bus.loss_valid && bus.loss_ready;
         if (ea) begin
            ee = (exp_err.size() > 0) ? exp_err.pop_front() : 'x;
            n_tests++; if (bus.error_data !== ee) begin n_fail++;
               $display("FAIL rand_err@%0d: got %h expected %h", c, bus.error_data, ee); end
         end
         if (la) begin
            el = (exp_loss.size() > 0) ? exp_loss.pop_front() : 'x;
            n_tests++; if (bus.loss_data !== el) begin n_fail++;
               $display("FAIL rand_loss@%0d: got %h expected %h", c, bus.loss_data, el); end
         end
         if (ta) tq.push_back(bus.target_data);
         if (ra) rq.push_back(bus.result_data);
         if (tq.size() > 0 && rq.size() > 0) begin
            t = tq.pop_front(); r = rq.pop_front();
            e = ref_err(t, r);
            if (train) exp_err.push_back(W'(e));
            acc += (e < 0) ? -e : e;
            if (acc > C_LMAX) acc = C_LMAX;
            cnt++;
            if (cnt == N) begin exp_loss.push_back(L'(acc)); acc = 0; cnt = 0; end
         end
         @(posedge clock); #1;
         if (ta) bus.target_valid = 1'b0;
         if (ra) bus.result_valid = 1'b0;
      end
      n_tests++; if (exp_err.size() != 0 || exp_loss.size() != 0) begin n_fail++;
         $display("FAIL rand_drain: got %0d errors %0d losses pending expected 0 0", exp_err.size(), exp_loss.size()); end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      train = 1'b0;
      test_reset();
      test_basic();
      test_saturation();
      test_order();
      test_batch();
      test_inference();
      test_reset_mid();
      test_random(2000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/objective.md
Name: objective

Overview:
- Closes the training loop around a product unit.
- Consumes the unit's result stream and a target stream, then returns the signed error (target − result) on the unit's error input.
- Accumulates the absolute error over a batch of N samples and reports it as a loss word.
- Sits between the training-data source and the product result/error ports, as the counterpart that drives what product consumes on its error port.

Parameters:
W, 16, width of target, result and error words (signed two's complement, Q8.8 for W=16)
N, 4, samples per batch; loss emitted after every N-th sample
L, 24, loss accumulator width (unsigned), L >= W+1

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
train  input  1  1 = issue error words; 0 = inference, loss only
target_valid  input  1  target word available
target_ready  output  1  block accepts target
target_data  input  W  signed target
result_valid  input  1  product result available
result_ready  output  1  block accepts result
result_data  input  W  signed result from product
error_valid  output  1  error word available
error_ready  input  1  product accepts error
error_data  output  W  signed saturated target − result
loss_valid  output  1  batch loss available
loss_ready  input  1  consumer accepts loss
loss_data  output  L  sum of |error| over last N samples, saturating

Behaviour:
- Handshake on all streams: transfer when valid && ready on a rising edge. Once raised, valid and data are held until the transfer.
- Reset (synchronous, any state, including mid-transfer):
  - state = COLLECT, sample counter = 0, accumulator = 0, both capture flags cleared.
  - All valid outputs 0; error_data = 0, loss_data = 0.
  - In COLLECT after reset: target_ready = 1, result_ready = 1.
- State COLLECT:
  - target_ready = !have_target; result_ready = !have_result.
  - Target and result may arrive in either order or in the same cycle. Each is captured into its own register and its flag is set.
  - On the edge where both are held (or the second arrives), the following happen in that edge:
    - compute e = sat_W(target − result) in W+1-bit arithmetic, clamped to [−2^(W−1), 2^(W−1)−1];
    - latch train;
    - clear both flags;
    - add |e| to the accumulator, saturating at 2^L−1; |−2^(W−1)| = 2^(W−1).
  - Next state: ERROR if train was latched as 1; otherwise ADVANCE logic applies immediately (see below).
- State ERROR:
  - error_valid = 1, error_data = e; target_ready = result_ready = 0.
  - On error_ready, ADVANCE logic applies.
  - Latency: error_valid rises exactly 1 cycle after the capturing edge.
- ADVANCE logic:
  - If counter == N−1: counter ← 0, loss_data ← accumulator (including the current |e|), accumulator ← 0, go to LOSS.
  - Otherwise: counter++, go to COLLECT.
- State LOSS:
  - loss_valid = 1; target_ready = result_ready = 0.
  - On loss_ready: go to COLLECT, loss_valid ← 0.
- Boundary rules:
  - Changing train mid-sample has no effect on a sample already captured.
  - error_data retains its last value when error_valid = 0.
  - No combinational path from any ready input to any ready output.
- Throughput:
  - With train=1 and sinks always ready: 1 sample per 2 cycles; LOSS adds 1 cycle per batch.
  - With train=0: 1 sample per cycle.

Test Plan:
1. Basic error path:
   - Stimulus: reset 2 cycles, train=1, target 0x007f, result 0xfff4 in the same cycle.
   - Required: error_valid high the next cycle with error_data 0x008b.
   - With error_ready held low 3 cycles: error_valid and error_data stable, and target_ready = result_ready = 0 throughout.
2. Saturation:
   - target 0x7fff, result 0x8000 → error_data 0x7fff.
   - target 0x8000, result 0x7fff → error_data 0x8000.
   - Accumulator adds 0x7fff and 0x8000.
3. Arrival order:
   - Stimulus: result 0x0010 presented 2 cycles before target 0x0020.
   - Required: result_ready drops after the result capture while target_ready stays 1; error_data 0x0010 exactly 1 cycle after the target capture.
4. Batch loss, N=4, train=1, errors 139, −5, 0, 2:
   - Required: loss_valid rises after the 4th error transfer with loss_data 0x000092.
   - With loss_ready low 5 cycles: no target/result accepted during that time. The next batch starts from 0.
5. Inference:
   - Stimulus: train=0, 4 samples with errors 1, −1, 1, −1, both streams valid every cycle.
   - Required: error_valid never rises; one sample accepted per cycle; loss_data 4.
6. Reset mid-operation:
   - Stimulus: after 2 samples with error_valid high, assert reset 1 cycle.
   - Required: all valids 0 next cycle. The next 4 samples (errors 3, 3, 3, 3) yield loss_data 12, with no contribution from the pre-reset samples.
